tdc_meas_sched: RTL

TDC_MEAS_SCHED -- requirements
Module: tdc_meas_sched

---
 rtl/tdc_pkg.sv | 29 ++
 rtl/tdc_edge_det.sv | 40 ++++
 rtl/tdc_meas_sched.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared types, default sizes and the hit-count clamp helper for the TDC measurement scheduler.
package tdc_pkg;

    localparam int HIT_MAX_DEF = 4;
    localparam int TW_DEF      = 16;
    localparam int TOW_DEF     = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_MEAS = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } tdc_state_e;

    // A request of zero still means "wait for one hit"; anything above the storage depth saturates.
    function automatic int unsigned clamp_hits(input int unsigned req, input int unsigned hit_max);
        int unsigned eff;
        if (req == 32'd0) begin
            eff = 32'd1;
        end else if (req > hit_max) begin
            eff = hit_max;
        end else begin
            eff = req;
        end
        return eff;
    endfunction

endpackage

// File: rtl/tdc_edge_det.sv
// Rising-edge detector for the start request; TDC_START_SYNC_EN adds a 2-flop synchronizer in front.
module tdc_edge_det (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_s;
    logic prev_q;

`ifdef TDC_START_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer for an asynchronous start level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sig_i};
        end
    end

    assign sig_s = sync_q[1];
`else
    assign sig_s = sig_i;
`endif

    // Edge-detect history.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_s;
        end
    end

    assign rise_o = sig_s & ~prev_q;

endmodule

// File: rtl/tdc_meas_sched.sv
// TDC measurement scheduler: arms the TDC core, stores stop hits into the result RAM, raises done/error.
// Optional TDC_START_SYNC_EN synchronizes tdc_start (adds 2 cycles of start latency).
module tdc_meas_sched
    import tdc_pkg::*;
#(
    parameter int HIT_MAX = HIT_MAX_DEF,
    parameter int TW      = TW_DEF,
    parameter int TOW     = TOW_DEF,
    localparam int AW     = (HIT_MAX > 1) ? $clog2(HIT_MAX) : 1,
    localparam int CW     = AW + 1
) (
    input  logic          clk_osc,
    input  logic          rst_n,
    input  logic          tdc_start,
    input  logic          cfg_en,
    input  logic [CW-1:0] cfg_hit_num,
    input  logic [TOW-1:0] cfg_timeout,
    output logic          tdc_arm,
    input  logic          tdc_hit_vld,
    input  logic [TW-1:0] tdc_hit_data,
    output logic          res_wr,
    output logic [AW-1:0] res_addr,
    output logic [TW-1:0] res_data,
    output logic          int_done,
    output logic          int_err,
    input  logic          int_clr
);

    tdc_state_e     state_q, state_d;
    logic [CW-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CW-1:0]  eff_q, eff_d;
    logic [TOW-1:0] timer_q, timer_d;
    logic           tdc_arm_q, res_wr_q, res_wr_d;
    logic [AW-1:0]  res_addr_q, res_addr_d;
    logic [TW-1:0]  res_data_q, res_data_d;
    logic           int_done_q, int_done_d, int_err_q, int_err_d;
    logic           start_rise_s, hit_last_s, timeout_s;

    tdc_edge_det u_edge_det (
        .clk_i   (clk_osc),
        .rst_n_i (rst_n),
        .sig_i   (tdc_start),
        .rise_o  (start_rise_s)
    );

    assign hit_last_s = ((hit_cnt_q + CW'(1)) == eff_q);
    assign timeout_s  = (cfg_timeout != '0) && (timer_q == (cfg_timeout - TOW'(1)));

    // Next-state, result-write and interrupt logic; an interrupt raised this cycle wins over int_clr.
    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        eff_d      = eff_q;
        timer_d    = timer_q;
        res_wr_d   = 1'b0;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;
        int_done_d = int_done_q;
        int_err_d  = int_err_q;
        if (int_clr) begin
            int_done_d = 1'b0;
            int_err_d  = 1'b0;
        end else begin
            int_done_d = int_done_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_rise_s && cfg_en) begin
                    state_d   = ST_ARM;
                    hit_cnt_d = '0;
                    timer_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!cfg_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MEAS;
                    eff_d   = CW'(clamp_hits(32'(cfg_hit_num), HIT_MAX));
                end
            end
            ST_MEAS: begin
                if (!cfg_en) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TOW'(1);
                    if (tdc_hit_vld) begin
                        res_wr_d   = 1'b1;
                        res_addr_d = hit_cnt_q[AW-1:0];
                        res_data_d = tdc_hit_data;
                        hit_cnt_d  = hit_cnt_q + CW'(1);
                    end else begin
                        res_wr_d = 1'b0;
                    end
                    if (tdc_hit_vld && hit_last_s) begin
                        state_d    = ST_DONE;
                        int_done_d = 1'b1;
                    end else if (timeout_s) begin
                        state_d   = ST_ERR;
                        int_err_d = 1'b1;
                    end else begin
                        state_d = ST_MEAS;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                if (int_clr) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_osc or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hit_cnt_q  <= '0;
            eff_q      <= '0;
            timer_q    <= '0;
            tdc_arm_q  <= 1'b0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
            int_done_q <= 1'b0;
            int_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            eff_q      <= eff_d;
            timer_q    <= timer_d;
            tdc_arm_q  <= (state_d == ST_MEAS);
            res_wr_q   <= res_wr_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
            int_done_q <= int_done_d;
            int_err_q  <= int_err_d;
        end
    end

    assign tdc_arm  = tdc_arm_q;
    assign res_wr   = res_wr_q;
    assign res_addr = res_addr_q;
    assign res_data = res_data_q;
    assign int_done = int_done_q;
    assign int_err  = int_err_q;

endmodule
